// File: rtl/dii_packet_framer.sv
// Frames each DII packet from a full-packet buffer as a length header word followed by its payload.
// Optional length checking is enabled by defining DII_PACKET_FRAMER_LENCHK_EN.
package dii_framer_pkg;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module dii_packet_framer #(
  parameter int BUF_SIZE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [$clog2(BUF_SIZE):0] packet_size,
  input  dii_framer_pkg::dii_flit   flit_in,
  output logic                      flit_in_ready,
  output logic [15:0]               word_out,
  output logic                      word_out_valid,
  input  logic                      word_out_ready,
  output logic                      busy,
  output logic                      len_err
);
  localparam int LW = $clog2(BUF_SIZE) + 1;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [LW-1:0] len;
  logic          start;
  logic          fire;

  // A packet is only started once the buffer reports a non-empty head packet.
  assign start = flit_in.valid && (packet_size != '0);
  assign fire  = (state == PAYLOAD) && flit_in.valid && word_out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = HEADER;
      HEADER:  if (word_out_ready) state_nxt = PAYLOAD;
      PAYLOAD: if (fire && flit_in.last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    flit_in_ready  = 1'b0;
    word_out_valid = 1'b0;
    word_out       = '0;
    busy           = 1'b0;
    case (state)
      HEADER: begin
        word_out       = 16'(len);
        word_out_valid = 1'b1;
        busy           = 1'b1;
      end
      PAYLOAD: begin
        word_out       = flit_in.data;
        word_out_valid = flit_in.valid;
        flit_in_ready  = word_out_ready;
        busy           = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                        len <= '0;
    else if (state == IDLE && start) len <= packet_size;
  end

`ifdef DII_PACKET_FRAMER_LENCHK_EN
  logic [LW-1:0] cnt;
  logic          len_err_q;

  // cnt tracks flits still owed by packet_size; the `last` flag alone ends framing.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      len_err_q <= 1'b0;
    end else begin
      if (state == IDLE && start)   cnt <= packet_size;
      else if (fire && cnt != '0)   cnt <= cnt - LW'(1);
      if (fire && ((flit_in.last && cnt != LW'(1)) || (!flit_in.last && cnt <= LW'(1))))
        len_err_q <= 1'b1;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_dii_packet_framer.sv
// Bench for dii_packet_framer: upstream buffer model, per-packet reference stream, directed and random traffic.
module tb_dii_packet_framer;
  localparam int BUF_SIZE = 4;
  localparam int LW = $clog2(BUF_SIZE) + 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [LW-1:0]           packet_size;
  dii_framer_pkg::dii_flit flit_in;
  logic                    flit_in_ready;
  logic [15:0]             word_out;
  logic                    word_out_valid;
  logic                    word_out_ready;
  logic                    busy;
  logic                    len_err;

  dii_packet_framer #(.BUF_SIZE(BUF_SIZE)) dut (
    .clk(clk), .rst(rst), .packet_size(packet_size), .flit_in(flit_in),
    .flit_in_ready(flit_in_ready), .word_out(word_out), .word_out_valid(word_out_valid),
    .word_out_ready(word_out_ready), .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } flit_t;

  flit_t       upq[$];
  int          szq[$];
  logic [15:0] got[$];
  int          got_cyc[$];
  logic [15:0] expq[$];
  bit          rdy_pat[$];
  int          stall_pct = 0;
  int          cyc = 0;
  int          busy_n, act_n;
  bit          err_exp = 0;
  bit          stalled_prev = 0;
  logic [15:0] stalled_word;
  int          compared = 0;
  int          mismatched = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_len_err();
`ifdef DII_PACKET_FRAMER_LENCHK_EN
    return err_exp;
`else
    return 1'b0;
`endif
  endfunction

  task automatic present();
    if (upq.size() > 0) begin
      flit_in.valid = 1'b1;
      flit_in.last  = upq[0].last;
      flit_in.data  = upq[0].data;
      packet_size   = LW'(szq[0]);
    end else begin
      flit_in     = '0;
      packet_size = '0;
    end
    if (rdy_pat.size() > 0) word_out_ready = rdy_pat.pop_front();
    else                    word_out_ready = ($urandom_range(0, 99) >= stall_pct);
  endtask

  // Sample at the falling edge, then update the buffer model and drive just after the rising edge.
  task automatic step();
    bit took;
    @(negedge clk);
    took = flit_in.valid && flit_in_ready;
    if (!rst && stalled_prev) begin
      check("hold_valid", word_out_valid, 1);
      check("hold_word", word_out, stalled_word);
    end
    if (!rst && busy && !word_out_ready) check("stall_no_pop", flit_in_ready, 0);
    stalled_prev = !rst && word_out_valid && !word_out_ready;
    stalled_word = word_out;
    if (word_out_valid && word_out_ready) begin
      got.push_back(word_out);
      got_cyc.push_back(cyc);
    end
    busy_n += int'(busy);
    act_n  += int'(flit_in.valid || busy);
    @(posedge clk);
    #1;
    cyc++;
    if (took) begin
      if (upq[0].last) void'(szq.pop_front());
      void'(upq.pop_front());
    end
    present();
  endtask

  task automatic push_pkt(int decl, logic [15:0] d[$]);
    flit_t f;
    szq.push_back(decl);
    foreach (d[i]) begin
      f.data = d[i];
      f.last = (i == d.size() - 1);
      upq.push_back(f);
    end
  endtask

  // Reference: every packet appears as its declared size followed by all its flits.
  task automatic enq(int decl, logic [15:0] d[$]);
    push_pkt(decl, d);
    expq.push_back(16'(decl));
    foreach (d[i]) expq.push_back(d[i]);
    if (d.size() != decl) err_exp = 1'b1;
  endtask

  task automatic run_until_idle(string tag, int maxc);
    int g = 0;
    while ((upq.size() != 0 || busy === 1'b1) && g < maxc) begin
      step();
      g++;
    end
    check({tag, "_done"}, (upq.size() == 0 && busy === 1'b0), 1);
  endtask

  task automatic compare_stream(string tag);
    check({tag, "_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      check(tag, (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(expq[i]));
    got.delete();
    got_cyc.delete();
    expq.delete();
  endtask

  initial begin
    logic [15:0] d[$];
    int c0, gap, g;

    rst = 1'b1;
    flit_in = '0;
    packet_size = '0;
    word_out_ready = 1'b0;
    present();
    repeat (3) step();
    check("rst_valid", word_out_valid, 0);
    check("rst_word", word_out, 0);
    check("rst_busy", busy, 0);
    check("rst_len_err", len_err, 0);
    check("rst_in_ready", flit_in_ready, 0);
    rst = 1'b0;
    step();

    // Basic header and pass-through.
    got.delete(); got_cyc.delete();
    busy_n = 0; act_n = 0; c0 = cyc;
    d.delete(); d.push_back(16'h1111); d.push_back(16'h2222); d.push_back(16'h3333);
    enq(3, d);
    present();
    run_until_idle("basic", 50);
    check("basic_hdr_latency", (got_cyc.size() > 0) ? got_cyc[0] - c0 : -1, 1);
    check("basic_cycles", act_n, 5);
    check("basic_busy_cycles", busy_n, 4);
    compare_stream("basic_word");
    check("basic_len_err", len_err, exp_len_err());

    // Stalls in HEADER and mid-payload.
    d.delete(); d.push_back(16'hA001); d.push_back(16'hA002); d.push_back(16'hA003);
    enq(3, d);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    present();
    run_until_idle("stall", 50);
    compare_stream("stall_word");

    // Back-to-back 1-flit and 4-flit packets.
    d.delete(); d.push_back(16'hB000);
    enq(1, d);
    d.delete(); d.push_back(16'hB001); d.push_back(16'hB002); d.push_back(16'hB003); d.push_back(16'hB004);
    enq(4, d);
    present();
    run_until_idle("b2b", 50);
    gap = (got_cyc.size() >= 3) ? got_cyc[2] - got_cyc[1] : -1;
    check("b2b_gap", gap, 2);
    compare_stream("b2b_word");
    check("b2b_len_err", len_err, exp_len_err());

    // Declared length 2 but `last` on the 3rd flit, then a clean packet.
    d.delete(); d.push_back(16'hC001); d.push_back(16'hC002); d.push_back(16'hC003);
    enq(2, d);
    present();
    run_until_idle("mism", 50);
    compare_stream("mism_word");
    check("mism_len_err", len_err, exp_len_err());
    d.delete(); d.push_back(16'hC101);
    enq(1, d);
    present();
    run_until_idle("sticky", 50);
    compare_stream("sticky_word");
    check("sticky_len_err", len_err, exp_len_err());

    // Reset after one payload word; remainder framed with the new packet_size.
    d.delete(); d.push_back(16'hD001); d.push_back(16'hD002); d.push_back(16'hD003);
    push_pkt(3, d);
    present();
    g = 0;
    while (got.size() < 2 && g < 20) begin step(); g++; end
    check("rstmid_reached", got.size(), 2);
    rst = 1'b1;
    word_out_ready = 1'b0;
    szq[0] = 2;
    step();
    check("rstmid_valid", word_out_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_len_err", len_err, 0);
    check("rstmid_in_ready", flit_in_ready, 0);
    rst = 1'b0;
    err_exp = 1'b0;
    run_until_idle("rstmid", 50);
    expq = '{16'h0003, 16'hD001, 16'h0002, 16'hD002, 16'hD003};
    compare_stream("rstmid_word");
    check("rstmid_len_err_after", len_err, exp_len_err());

    // Random packets with random backpressure and occasional length mismatches.
    stall_pct = 40;
    for (int p = 0; p < 25; p++) begin
      int n, decl;
      n = $urandom_range(1, 4);
      decl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : n;
      d.delete();
      for (int k = 0; k < n; k++) d.push_back(16'($urandom));
      enq(decl, d);
    end
    present();
    run_until_idle("rand", 3000);
    compare_stream("rand_word");
    check("rand_len_err", len_err, exp_len_err());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
